iq_sweep_controller: RTL
========================

// Module: iq_sweep_controller
// PURPOSE
//  Frequency-sweep sequencer for IQ_mod_demod. Steps the NCO frequency tuning word from
//  ftw_start to ftw_stop, waits for the carrier to settle, then integrates 2**ACC_LOG2
//  valid I/Q samples per point. One (ftw, I_sum, Q_sum) record per point is emitted on a
//  valid/ready port. Sits between the host/config registers and the IQ datapath.
// PARAMETERS
//  FTW_W       8    tuning-word width (matches IQ_mod_demod.freq_tuning_word)
//  DATA_W      48   width of the signed I/Q products from the datapath
//  ACC_LOG2    8    log2 of samples integrated per point (256)
//  SETTLE_CYC  16   clocks between a tuning-word change and the first counted sample
// PORTS
//  clk             in   1                 system clock
//  reset_n         in   1                 synchronous active-low reset
//  start           in   1                 1-cycle sweep request; sampled only in IDLE
//  ftw_start       in   FTW_W             first tuning word (captured on accepted start)
//  ftw_stop        in   FTW_W             last allowed tuning word (inclusive)
//  ftw_step        in   FTW_W             increment per point, unsigned
//  freq_tuning_word out FTW_W             drives IQ_mod_demod.freq_tuning_word
//  dp_enable       out  1                 high in SETTLE/ACCUM only; gates the datapath
//  dp_valid        in   1                 datapath sample strobe (enable_out)
//  i_in, q_in      in   DATA_W            signed I/Q samples (q_I_mod / q_Q_mod)
//  res_valid       out  1                 result record valid
//  res_ready       in   1                 result consumer ready
//  res_ftw         out  FTW_W             tuning word of this record
//  res_i, res_q    out  DATA_W+ACC_LOG2   signed integrated I and Q
//  busy            out  1                 high in every state except IDLE
//  done            out  1                 1-cycle pulse after the last record is accepted
//  cfg_err         out  1                 1-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE; all outputs 0; accumulators, counters cleared.
//  Reset mid-sweep aborts immediately; no done pulse, pending record discarded.
//  FSM: IDLE -> LOAD -> SETTLE -> ACCUM -> REPORT -> (LOAD | DONE) ; DONE -> IDLE.
//  IDLE: on start, if ftw_step==0 or ftw_start>ftw_stop -> cfg_err=1 next cycle, stay IDLE;
//        else capture cfg, cur_ftw=ftw_start, go LOAD. start in any other state ignored.
//  LOAD: (1 cycle) freq_tuning_word<=cur_ftw; clear accumulators and counters.
//  SETTLE: dp_enable=1; count SETTLE_CYC clocks regardless of dp_valid, then ACCUM.
//  ACCUM: add sign-extended i_in/q_in on each cycle with dp_valid=1; cycles with
//        dp_valid=0 neither add nor count. After the 2**ACC_LOG2-th sample -> REPORT.
//        Accumulator width DATA_W+ACC_LOG2 cannot overflow; no saturation logic.
//  REPORT: dp_enable=0; res_valid=1 with res_* stable until res_valid&&res_ready.
//        On handshake: next=cur_ftw+ftw_step computed in FTW_W+1 bits; if next>ftw_stop
//        (incl. carry out / wrap) -> DONE, else cur_ftw=next -> LOAD. res_ready may be
//        held high; one record per point, no duplicates.
//  DONE: done=1 for one cycle, freq_tuning_word held at last point, -> IDLE.
//  Latency: accepted start at edge N -> freq_tuning_word valid after edge N+2;
//        first counted sample no earlier than edge N+2+SETTLE_CYC.
//  Points per sweep = floor((ftw_stop-ftw_start)/ftw_step)+1; ftw_start==ftw_stop -> 1.
//  res_valid deasserts the cycle after handshake; never high outside REPORT.
// STRUCTURE
//  Package iq_ctrl_pkg: state enum (IDLE,LOAD,SETTLE,ACCUM,REPORT,DONE), default widths,
//  result record struct {ftw,i,q} for reuse by the host-side readback block.
//  Sub-module iq_accumulator: clear/enable, sign-extending DATA_W -> DATA_W+ACC_LOG2 adder,
//  instantiated twice (I and Q). FSM, counters and step arithmetic stay in this module.
// TESTING
//  T1 reset: hold reset_n=0 4000 ns with start pulsed -> all outputs 0, busy=0, no record.
//  T2 sweep 5..20 step 5, dp_valid=1, i_in=+3, q_in=-2, res_ready=1 -> 4 records
//     ftw=5,10,15,20; res_i=768, res_q=-512 each; one done pulse after the 4th handshake.
//  T3 dp_valid toggling 1/0 every cycle -> same sums as T2, ACCUM lasts 2x clocks.
//  T4 backpressure: res_ready=0 for 50 cycles in REPORT -> res_* stable, dp_enable=0,
//     freq_tuning_word unchanged; release -> next point proceeds.
//  T5 wrap: start=250 stop=255 step=4 -> records 250,254 only; start=7 stop=3 or step=0
//     -> cfg_err pulse, busy stays 0.
//  T6 reset_n=0 for one cycle mid-ACCUM, then new start 1..1 step 1 -> exactly one record
//     ftw=1, sums unaffected by the aborted sweep.

Source files
------------

// File: rtl/iq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_ctrl_pkg
// Purpose  : Shared types and default widths for the IQ sweep controller and
//            the host-side readback block.
// Contents : state_t        - sweep sequencer states
//            *_DEF          - default parameter widths
//            res_rec_t      - one result record {ftw, i, q} at default widths
// Revision : 1.0 - initial release
// ============================================================================
package iq_ctrl_pkg;

    localparam int FTW_W_DEF      = 8;
    localparam int DATA_W_DEF     = 48;
    localparam int ACC_LOG2_DEF   = 8;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int RES_W_DEF      = DATA_W_DEF + ACC_LOG2_DEF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic        [FTW_W_DEF-1:0] ftw;
        logic signed [RES_W_DEF-1:0] i;
        logic signed [RES_W_DEF-1:0] q;
    } res_rec_t;

endpackage : iq_ctrl_pkg
`default_nettype wire

// File: rtl/iq_sweep_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : iq_sweep_controller_if
// Purpose  : Bundles the host config/control, the IQ datapath link and the
//            result stream of the sweep controller.
// Modports : slave  - the sweep controller itself
//            master - the surrounding host/datapath/consumer side
// Signals  : start, ftw_start/stop/step      host -> controller
//            freq_tuning_word, dp_enable     controller -> datapath
//            dp_valid, i_in, q_in            datapath -> controller
//            res_valid/ready, res_ftw/i/q    result valid/ready stream
//            busy, done, cfg_err             status
// Revision : 1.0 - initial release
// ============================================================================
interface iq_sweep_controller_if
    import iq_ctrl_pkg::*;
#(
    parameter int FTW_W    = FTW_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ACC_LOG2 = ACC_LOG2_DEF
);
    localparam int RES_W = DATA_W + ACC_LOG2;

    logic                     start;
    logic        [FTW_W-1:0]  ftw_start;
    logic        [FTW_W-1:0]  ftw_stop;
    logic        [FTW_W-1:0]  ftw_step;
    logic        [FTW_W-1:0]  freq_tuning_word;
    logic                     dp_enable;
    logic                     dp_valid;
    logic signed [DATA_W-1:0] i_in;
    logic signed [DATA_W-1:0] q_in;
    logic                     res_valid;
    logic                     res_ready;
    logic        [FTW_W-1:0]  res_ftw;
    logic signed [RES_W-1:0]  res_i;
    logic signed [RES_W-1:0]  res_q;
    logic                     busy;
    logic                     done;
    logic                     cfg_err;

    modport slave (
        input  start, ftw_start, ftw_stop, ftw_step,
        input  dp_valid, i_in, q_in, res_ready,
        output freq_tuning_word, dp_enable,
        output res_valid, res_ftw, res_i, res_q,
        output busy, done, cfg_err
    );

    modport master (
        output start, ftw_start, ftw_stop, ftw_step,
        output dp_valid, i_in, q_in, res_ready,
        input  freq_tuning_word, dp_enable,
        input  res_valid, res_ftw, res_i, res_q,
        input  busy, done, cfg_err
    );

endinterface : iq_sweep_controller_if
`default_nettype wire

// File: rtl/iq_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : iq_accumulator
// Purpose  : Signed integrator. Sign-extends each DATA_W sample to
//            DATA_W+ACC_LOG2 bits and adds it when enabled; the extra
//            ACC_LOG2 bits absorb 2**ACC_LOG2 full-scale samples, so no
//            saturation is needed.
// Ports    : clk, reset_n (sync, active low)
//            clear_i  - zero the sum (priority over enable)
//            en_i     - add data_i this cycle
//            data_i   - signed sample
//            acc_o    - running signed sum
// Revision : 1.0 - initial release
// ============================================================================
module iq_accumulator #(
    parameter int DATA_W   = 48,
    parameter int ACC_LOG2 = 8
) (
    input  wire logic                              clk,
    input  wire logic                              reset_n,
    input  wire logic                              clear_i,
    input  wire logic                              en_i,
    input  wire logic signed [DATA_W-1:0]          data_i,
    output      logic signed [DATA_W+ACC_LOG2-1:0] acc_o
);
    localparam int ACC_W = DATA_W + ACC_LOG2;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] data_ext;

    assign data_ext = {{ACC_LOG2{data_i[DATA_W-1]}}, data_i};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + data_ext;
        end
    end

    assign acc_o = acc_q;

endmodule : iq_accumulator
`default_nettype wire

// File: rtl/iq_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : iq_sweep_controller
// Purpose  : Frequency-sweep sequencer for IQ_mod_demod. Steps the NCO tuning
//            word from ftw_start to ftw_stop, waits SETTLE_CYC clocks per
//            point, integrates 2**ACC_LOG2 valid I/Q samples and emits one
//            {ftw, I_sum, Q_sum} record per point on a valid/ready stream.
// Ports    : clk, reset_n (sync, active low)
//            bus - iq_sweep_controller_if.slave (config, datapath, results,
//                  status)
// Revision : 1.0 - initial release
// ============================================================================
module iq_sweep_controller
    import iq_ctrl_pkg::*;
#(
    parameter int FTW_W      = FTW_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACC_LOG2   = ACC_LOG2_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input wire logic             clk,
    input wire logic             reset_n,
    iq_sweep_controller_if.slave bus
);
    localparam int RES_W = DATA_W + ACC_LOG2;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [ACC_LOG2-1:0] SMP_LAST = '1;

    state_t               state_q, state_d;
    logic [FTW_W-1:0]     cur_ftw_q, cur_ftw_d;
    logic [FTW_W-1:0]     stop_q, stop_d;
    logic [FTW_W-1:0]     step_q, step_d;
    logic [FTW_W-1:0]     ftw_out_q, ftw_out_d;
    logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
    logic [ACC_LOG2-1:0]  smp_cnt_q, smp_cnt_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 acc_clr;
    logic                 acc_en;
    logic [FTW_W:0]       nxt_ftw;
    logic signed [RES_W-1:0] sum_i, sum_q;

    // One extra bit so a step that wraps past 2**FTW_W-1 still compares as
    // beyond ftw_stop and ends the sweep.
    assign nxt_ftw = {1'b0, cur_ftw_q} + {1'b0, step_q};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_ftw_q <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            ftw_out_q <= '0;
            set_cnt_q <= '0;
            smp_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ftw_q <= cur_ftw_d;
            stop_q    <= stop_d;
            step_q    <= step_d;
            ftw_out_q <= ftw_out_d;
            set_cnt_q <= set_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ftw_d = cur_ftw_q;
        stop_d    = stop_q;
        step_d    = step_q;
        ftw_out_d = ftw_out_q;
        set_cnt_d = set_cnt_q;
        smp_cnt_d = smp_cnt_q;
        cfg_err_d = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.ftw_step == '0) || (bus.ftw_start > bus.ftw_stop)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cur_ftw_d = bus.ftw_start;
                        stop_d    = bus.ftw_stop;
                        step_d    = bus.ftw_step;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ftw_out_d = cur_ftw_q;
                set_cnt_d = '0;
                smp_cnt_d = '0;
                acc_clr   = 1'b1;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Settling time is wall-clock, not sample count.
                if (set_cnt_q == SET_LAST) begin
                    set_cnt_d = '0;
                    state_d   = ST_ACCUM;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_ACCUM: begin
                if (bus.dp_valid) begin
                    acc_en    = 1'b1;
                    smp_cnt_d = smp_cnt_q + 1'b1;
                    if (smp_cnt_q == SMP_LAST) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    if (nxt_ftw > {1'b0, stop_q}) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_ftw_d = nxt_ftw[FTW_W-1:0];
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    iq_accumulator #(
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_acc_i (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (acc_clr),
        .en_i    (acc_en),
        .data_i  (bus.i_in),
        .acc_o   (sum_i)
    );

    iq_accumulator #(
        .DATA_W   (DATA_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_acc_q (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (acc_clr),
        .en_i    (acc_en),
        .data_i  (bus.q_in),
        .acc_o   (sum_q)
    );

    // Accumulators only change in LOAD/ACCUM, so the record is stable for
    // the whole REPORT phase regardless of backpressure.
    assign bus.freq_tuning_word = ftw_out_q;
    assign bus.dp_enable        = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
    assign bus.res_valid        = (state_q == ST_REPORT);
    assign bus.res_ftw          = cur_ftw_q;
    assign bus.res_i            = sum_i;
    assign bus.res_q            = sum_q;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.done             = (state_q == ST_DONE);
    assign bus.cfg_err          = cfg_err_q;

endmodule : iq_sweep_controller
`default_nettype wire
